entropy_block_builder: RTL

- Upstream feeder for the SHA-256 conditioner in the TRNG datapath.
- Collects raw ring-oscillator bits into a message register and applies SHA-256 single-block padding to form the 512-bit `M`.
- Issues a one-cycle `start` to the hash core and holds `M` stable until `hash_rdy`.
- Runs a repetition-count health test on incoming bits; a failing block is discarded before hashing.

---
 rtl/entropy_pkg.sv | 37 +++
 rtl/entropy_block_builder_if.sv | 26 ++
 rtl/rct_monitor.sv | 43 ++++
 rtl/entropy_block_builder.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/entropy_pkg.sv
// Shared types, widths and the SHA-256 single-block padding helper for the
// entropy block builder.
package entropy_pkg;

    localparam int LEN_FIELD_W = 64;
    localparam int BLOCK_W     = 512;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        PAD     = 3'd2,
        START   = 3'd3,
        WAIT    = 3'd4
    } state_t;

    // Keep the top msg_bits message bits, append the 1 marker, zero-fill,
    // and place the bit length in the low 64 bits.
    function automatic logic [BLOCK_W-1:0] pad_block(
        input logic [BLOCK_W-1:0] msg,
        input int                 msg_bits
    );
        logic [BLOCK_W-1:0] blk;
        blk = msg;
        for (int i = LEN_FIELD_W; i < BLOCK_W; i++) begin
            if (i == BLOCK_W - 1 - msg_bits) begin
                blk[i] = 1'b1;
            end else if (i < BLOCK_W - 1 - msg_bits) begin
                blk[i] = 1'b0;
            end else begin
                blk[i] = msg[i];
            end
        end
        blk[LEN_FIELD_W-1:0] = LEN_FIELD_W'(msg_bits);
        return blk;
    endfunction

endpackage

// File: rtl/entropy_block_builder_if.sv
// Bit stream, hash-core handshake and status signals of the entropy block
// builder, grouped for connection between the builder and its environment.
interface entropy_block_builder_if;
    import entropy_pkg::*;

    logic               enable;
    logic               bit_in;
    logic               bit_valid;
    logic               hash_rdy;
    logic [BLOCK_W-1:0] M;
    logic               start;
    logic               busy;
    logic               health_fail;
    logic [7:0]         drop_cnt;

    modport master (
        output enable, bit_in, bit_valid, hash_rdy,
        input  M, start, busy, health_fail, drop_cnt
    );

    modport slave (
        input  enable, bit_in, bit_valid, hash_rdy,
        output M, start, busy, health_fail, drop_cnt
    );

endinterface

// File: rtl/rct_monitor.sv
// Repetition-count health test: trip pulses combinationally on the accepted
// bit that makes the run of identical bits reach RCT_LIMIT.
module rct_monitor #(
    parameter int RCT_LIMIT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic bit_in,
    input  logic valid,
    output logic trip
);

    logic [7:0] run_r;
    logic       prev_r;
    logic       same_s;
    logic [7:0] run_next_s;

    // A run length of zero means no history, so the next bit starts a new run.
    always_comb begin
        same_s     = (run_r != 8'd0) && (bit_in == prev_r);
        run_next_s = same_s ? (run_r + 8'd1) : 8'd1;
        trip       = valid && !clear && (run_next_s == 8'(RCT_LIMIT));
    end

    // Run length and previous-bit history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_r  <= 8'd0;
            prev_r <= 1'b0;
        end else if (clear) begin
            run_r  <= 8'd0;
            prev_r <= 1'b0;
        end else if (valid) begin
            run_r  <= trip ? 8'd0 : run_next_s;
            prev_r <= bit_in;
        end else begin
            run_r  <= run_r;
            prev_r <= prev_r;
        end
    end

endmodule

// File: rtl/entropy_block_builder.sv
// Collects raw entropy bits into a SHA-256 single-block message, pads it,
// starts the hash core and holds the block until the core reports done.
module entropy_block_builder
    import entropy_pkg::*;
#(
    parameter int MSG_BITS  = 440,
    parameter int RCT_LIMIT = 32
) (
    input logic                    clk,
    input logic                    rst_n,
    entropy_block_builder_if.slave bus
);

    state_t             state_r;
    state_t             next_state_s;
    logic [8:0]         cnt_r;
    logic [BLOCK_W-1:0] m_r;
    logic               start_r;
    logic               busy_r;
    logic               health_fail_r;
    logic [7:0]         drop_cnt_r;

    logic               accept_s;
    logic               last_s;
    logic               trip_s;
    logic               rct_clear_s;
    logic               drop_s;
    logic [8:0]         idx_s;

    rct_monitor #(
        .RCT_LIMIT (RCT_LIMIT)
    ) u_rct (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (rct_clear_s),
        .bit_in (bus.bit_in),
        .valid  (accept_s),
        .trip   (trip_s)
    );

    // Datapath qualifiers; run history is cleared whenever no block is open.
    always_comb begin
        accept_s    = (state_r == COLLECT) && bus.bit_valid;
        last_s      = accept_s && (cnt_r == 9'(MSG_BITS - 1));
        rct_clear_s = (state_r != COLLECT);
        drop_s      = bus.bit_valid &&
                      ((state_r == PAD) || (state_r == START) || (state_r == WAIT));
        idx_s       = 9'(BLOCK_W - 1) - cnt_r;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; an RCT trip on the final bit wins over PAD.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.enable) begin
                    next_state_s = COLLECT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            COLLECT: begin
                if (last_s && !trip_s) begin
                    next_state_s = PAD;
                end else begin
                    next_state_s = COLLECT;
                end
            end
            PAD:   next_state_s = START;
            START: next_state_s = WAIT;
            WAIT: begin
                if (bus.hash_rdy) begin
                    next_state_s = bus.enable ? COLLECT : IDLE;
                end else begin
                    next_state_s = WAIT;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Message register and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_r   <= {BLOCK_W{1'b0}};
            cnt_r <= 9'd0;
        end else begin
            case (state_r)
                COLLECT: begin
                    if (accept_s && trip_s) begin
                        m_r   <= {BLOCK_W{1'b0}};
                        cnt_r <= 9'd0;
                    end else if (accept_s) begin
                        m_r[idx_s] <= bus.bit_in;
                        cnt_r      <= cnt_r + 9'd1;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                PAD: begin
                    m_r <= pad_block(m_r, MSG_BITS);
                end
                WAIT: begin
                    if (bus.hash_rdy) begin
                        cnt_r <= 9'd0;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    m_r   <= m_r;
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Registered status outputs; start and busy follow the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_r       <= 1'b0;
            busy_r        <= 1'b0;
            health_fail_r <= 1'b0;
            drop_cnt_r    <= 8'd0;
        end else begin
            start_r       <= (next_state_s == START);
            busy_r        <= (next_state_s != IDLE);
            health_fail_r <= health_fail_r | (accept_s && trip_s);
            if (drop_s && (drop_cnt_r != 8'hFF)) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign bus.M           = m_r;
    assign bus.start       = start_r;
    assign bus.busy        = busy_r;
    assign bus.health_fail = health_fail_r;
    assign bus.drop_cnt    = drop_cnt_r;

endmodule
